// File: rtl/opl_timer_bank.sv
// rtl/opl_timer_bank.sv - OPL preset-reload timer bank; OPL_TIMER_EXT_TICK_EN selects external base tick
module opl_timer_bank #(
   parameter int         NUM_TIMERS       = 2,
   parameter int         TIMER_WIDTH      = 8,
   parameter int         BASE_TICK_CYCLES = 5600,
   parameter int         TICK_SHIFT       = 2,
   parameter logic [7:0] PRESET_BASE_ADDR = 8'h02,
   parameter logic [7:0] CTRL_ADDR        = 8'h04
) (
   input  logic       clk,
   input  logic       ic_n,
   input  logic       wr_valid,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
`ifdef OPL_TIMER_EXT_TICK_EN
   input  logic       tick_ext,
`endif
   output logic [7:0] status,
   output logic       irq_n
);

   generate
      if (NUM_TIMERS < 1 || NUM_TIMERS > 3) begin : g_bad_num_timers
         $error("opl_timer_bank: NUM_TIMERS must be in 1..3");
      end
      if (BASE_TICK_CYCLES < 1) begin : g_bad_base_tick
         $error("opl_timer_bank: BASE_TICK_CYCLES must be at least 1");
      end
   endgenerate

   logic base_tick;

`ifdef OPL_TIMER_EXT_TICK_EN
   // Caller supplies synchronous single-cycle pulses, so no synchroniser here.
   assign base_tick = tick_ext;
`else
   localparam int PW = (BASE_TICK_CYCLES > 1) ? $clog2(BASE_TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(BASE_TICK_CYCLES - 1);

   logic [PW-1:0] pre_cnt;

   assign base_tick = (pre_cnt == PRE_LAST);

   // Free-running base prescaler, independent of any start bit
   always_ff @(posedge clk or negedge ic_n) begin
      if (!ic_n) begin
         pre_cnt <= '0;
      end else if (base_tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end
`endif

   logic ctrl_wr;
   logic irq_clr;
   logic ctrl_set;
   logic [NUM_TIMERS-1:0] flags;

   assign ctrl_wr  = wr_valid && (wr_addr == CTRL_ADDR);
   assign irq_clr  = ctrl_wr && wr_data[7];
   assign ctrl_set = ctrl_wr && !wr_data[7];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
         localparam int         SW      = TICK_SHIFT * gi;
         localparam logic [7:0] MY_ADDR = PRESET_BASE_ADDR + 8'(gi);

         logic                   tick;
         logic [TIMER_WIDTH-1:0] preset_q;
         logic [TIMER_WIDTH-1:0] cnt_q;
         logic                   start_q;
         logic                   mask_q;
         logic                   flag_q;
         logic                   start_rise;
         logic                   ovf;

         if (SW == 0) begin : g_nodiv
            assign tick = base_tick;
         end else begin : g_div
            logic [SW-1:0] sub_cnt;

            // Free-running sub-divider over base ticks
            always_ff @(posedge clk or negedge ic_n) begin
               if (!ic_n) begin
                  sub_cnt <= '0;
               end else if (base_tick) begin
                  sub_cnt <= sub_cnt + SW'(1);
               end
            end

            assign tick = base_tick && (&sub_cnt);
         end

         // start_rise implies the timer was stopped, so a tick in that cycle is dropped
         assign start_rise = ctrl_set && wr_data[gi] && !start_q;
         assign ovf        = start_q && tick && (&cnt_q);

         // Preset, start and mask registers
         always_ff @(posedge clk or negedge ic_n) begin
            if (!ic_n) begin
               preset_q <= '0;
               start_q  <= 1'b0;
               mask_q   <= 1'b0;
            end else begin
               if (wr_valid && (wr_addr == MY_ADDR)) begin
                  preset_q <= TIMER_WIDTH'(wr_data);
               end
               if (ctrl_set) begin
                  start_q <= wr_data[gi];
                  mask_q  <= wr_data[6-gi];
               end
            end
         end

         // Counter: load on start, count on tick, reload from preset on overflow
         always_ff @(posedge clk or negedge ic_n) begin
            if (!ic_n) begin
               cnt_q <= '0;
            end else if (start_rise) begin
               cnt_q <= preset_q;
            end else if (start_q && tick) begin
               cnt_q <= (&cnt_q) ? preset_q : cnt_q + TIMER_WIDTH'(1);
            end
         end

         // Sticky overflow flag; an overflow beats a simultaneous IRQ reset
         always_ff @(posedge clk or negedge ic_n) begin
            if (!ic_n) begin
               flag_q <= 1'b0;
            end else if (ovf && !mask_q) begin
               flag_q <= 1'b1;
            end else if (irq_clr) begin
               flag_q <= 1'b0;
            end
         end

         assign flags[gi] = flag_q;
      end
   endgenerate

   // Status byte built directly from the flag registers
   always_comb begin
      status = 8'h00;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         status[6-i] = flags[i];
      end
      status[7] = |flags;
   end

   assign irq_n = ~status[7];

endmodule

// File: tb/tb_opl_timer_bank.sv
// tb/tb_opl_timer_bank.sv - directed self-checking bench for opl_timer_bank
module tb_opl_timer_bank;

   logic       clk = 1'b0;
   logic       ic_n;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] status;
   logic       irq_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   opl_timer_bank #(
      .NUM_TIMERS(2),
      .TIMER_WIDTH(8),
      .BASE_TICK_CYCLES(4),
      .TICK_SHIFT(2),
      .PRESET_BASE_ADDR(8'h02),
      .CTRL_ADDR(8'h04)
   ) dut (
      .clk(clk),
      .ic_n(ic_n),
      .wr_valid(wr_valid),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .status(status),
      .irq_n(irq_n)
   );

   // Called at a negedge; the write occupies the next posedge and returns at the following negedge.
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
      wr_addr  = 8'h00;
      wr_data  = 8'h00;
   endtask

   task automatic wait_flag(input int b, input int limit, output int k);
      k = 0;
      while (status[b] !== 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset;
      ic_n     = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = 8'h00;
      wr_data  = 8'h00;
      repeat (3) @(negedge clk);
      total++;
      if (status !== 8'h00 || irq_n !== 1'b1) begin
         bad++;
         $display("FAIL reset_hold status=%h irq_n=%b exp 00/1", status, irq_n);
      end
      ic_n = 1'b1;
      @(negedge clk);
      total++;
      if (status !== 8'h00 || irq_n !== 1'b1) begin
         bad++;
         $display("FAIL reset_release status=%h irq_n=%b exp 00/1", status, irq_n);
      end
   endtask

   task automatic test_timer0;
      int k;
      wr(8'h02, 8'hFE);
      wr(8'h04, 8'h01);
      wait_flag(6, 20, k);
      total++;
      if (k < 5 || k > 8) begin
         bad++;
         $display("FAIL t0_first_delay got=%0d exp 5..8", k);
      end
      total++;
      if (status !== 8'hC0 || irq_n !== 1'b0) begin
         bad++;
         $display("FAIL t0_status status=%h irq_n=%b exp C0/0", status, irq_n);
      end
      for (int r = 0; r < 2; r++) begin
         wr(8'h04, 8'h80);
         total++;
         if (status !== 8'h00) begin
            bad++;
            $display("FAIL t0_clear status=%h exp 00", status);
         end
         wait_flag(6, 20, k);
         total++;
         if (k + 1 != 8) begin
            bad++;
            $display("FAIL t0_period got=%0d exp 8", k + 1);
         end
      end
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
   endtask

   task automatic test_timer1;
      int k;
      wr(8'h03, 8'hFF);
      wr(8'h04, 8'h02);
      wait_flag(5, 40, k);
      total++;
      if (status !== 8'hA0 || irq_n !== 1'b0) begin
         bad++;
         $display("FAIL t1_status status=%h irq_n=%b exp A0/0", status, irq_n);
      end
      for (int r = 0; r < 2; r++) begin
         wr(8'h04, 8'h80);
         wait_flag(5, 40, k);
         total++;
         if (k + 1 != 16) begin
            bad++;
            $display("FAIL t1_period got=%0d exp 16", k + 1);
         end
      end
      wr(8'h05, 8'h80);
      wr(8'h84, 8'h80);
      total++;
      if (status !== 8'hA0) begin
         bad++;
         $display("FAIL bad_addr_ignored status=%h exp A0", status);
      end
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
   endtask

   task automatic test_mask;
      int k;
      int viol;
      wr(8'h02, 8'hFF);
      wr(8'h04, 8'h41);
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (status !== 8'h00 || irq_n !== 1'b1) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL mask_quiet bad_cycles=%0d exp 0", viol);
      end
      wr(8'h04, 8'h01);
      wait_flag(6, 8, k);
      total++;
      if (status !== 8'hC0) begin
         bad++;
         $display("FAIL unmask_flag status=%h exp C0", status);
      end
      wr(8'h04, 8'h80);
      wait_flag(6, 8, k);
      total++;
      if (k + 1 != 4) begin
         bad++;
         $display("FAIL ff_period got=%0d exp 4", k + 1);
      end
   endtask

   task automatic test_irq_clear;
      int k;
      int viol;
      wr(8'h04, 8'h23);
      wr(8'h04, 8'h80);
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (status[5] !== 1'b0) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL mask_kept bad_cycles=%0d exp 0", viol);
      end
      for (int t = 0; t < 3; t++) begin
         wr(8'h04, 8'h80);
         if (status[6] === 1'b0) break;
      end
      wait_flag(6, 8, k);
      wr(8'h04, 8'h80);
      total++;
      if (status !== 8'h00 || irq_n !== 1'b1) begin
         bad++;
         $display("FAIL irq_clear status=%h irq_n=%b exp 00/1", status, irq_n);
      end
      wait_flag(6, 8, k);
      total++;
      if (k + 1 != 4 || status !== 8'hC0) begin
         bad++;
         $display("FAIL start_kept period=%0d status=%h exp 4/C0", k + 1, status);
      end
      repeat (3) @(negedge clk);
      wr(8'h04, 8'h80);
      total++;
      if (status !== 8'hC0) begin
         bad++;
         $display("FAIL ovf_beats_clear status=%h exp C0", status);
      end
      @(negedge clk);
      total++;
      if (status !== 8'hC0) begin
         bad++;
         $display("FAIL flag_sticky status=%h exp C0", status);
      end
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
   endtask

   task automatic test_preset_change;
      int k;
      wr(8'h02, 8'hF0);
      wr(8'h04, 8'h01);
      wait_flag(6, 100, k);
      total++;
      if (status !== 8'hC0) begin
         bad++;
         $display("FAIL f0_first status=%h exp C0", status);
      end
      wr(8'h04, 8'h80);
      wr(8'h02, 8'hFC);
      wait_flag(6, 100, k);
      total++;
      if (k + 2 != 64) begin
         bad++;
         $display("FAIL old_period got=%0d exp 64", k + 2);
      end
      wr(8'h04, 8'h80);
      wait_flag(6, 40, k);
      total++;
      if (k + 1 != 16) begin
         bad++;
         $display("FAIL new_period got=%0d exp 16", k + 1);
      end
      wr(8'h04, 8'h00);
      wr(8'h04, 8'h80);
   endtask

   task automatic test_async_reset;
      int k;
      int viol;
      wr(8'h02, 8'hFF);
      wr(8'h04, 8'h01);
      wait_flag(6, 8, k);
      total++;
      if (status !== 8'hC0) begin
         bad++;
         $display("FAIL pre_reset_flag status=%h exp C0", status);
      end
      #2 ic_n = 1'b0;
      #1;
      total++;
      if (status !== 8'h00 || irq_n !== 1'b1) begin
         bad++;
         $display("FAIL async_reset status=%h irq_n=%b exp 00/1", status, irq_n);
      end
      @(negedge clk);
      ic_n = 1'b1;
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (status !== 8'h00) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL stopped_after_reset bad_cycles=%0d exp 0", viol);
      end
      wr(8'h04, 8'h01);
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (status !== 8'h00) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL preset_cleared bad_cycles=%0d exp 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_timer0();
      test_timer1();
      test_mask();
      test_irq_clear();
      test_preset_change();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/opl_timer_bank.md
Name: opl_timer_bank

Overview:
- Parametrised successor to the fixed two-timer OPL2 timer logic.
- Provides NUM_TIMERS preset-reload up-counters with per-timer tick period, mask, start, and a shared overflow status/IRQ.
- Sits beside the register file: it snoops the same register-write stream (valid/address/data) and drives the status byte and IRQ to the host interface.
- Replaces the hardwired 80 us / 320 us timers whenever INSTANTIATE_TIMERS is set.

Parameters:
- NUM_TIMERS, 2: number of timers, legal range 1..3.
- TIMER_WIDTH, 8: preset/counter width in bits.
- BASE_TICK_CYCLES, 5600: clk cycles per base tick. 80 us at 70 MHz.
- TICK_SHIFT, 2: timer i period = BASE_TICK_CYCLES << (TICK_SHIFT*i). Gives 80 us and 320 us.
- PRESET_BASE_ADDR, 8'h02: timer i preset register is at PRESET_BASE_ADDR+i.
- CTRL_ADDR, 8'h04: control register address.

Ports:
- clk  in  1  master clock.
- ic_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  register write strobe, single cycle.
- wr_addr  in  8  register address.
- wr_data  in  8  register data.
- status  out  8  bit7 = IRQ; bit(6-i) = overflow flag of timer i; other bits 0.
- irq_n  out  1  active-low IRQ, equal to ~status[7].
- tick_ext  in  1  external base-tick enable. Present only with OPL_TIMER_EXT_TICK_EN.

Behaviour:
- Reset: one clock; ic_n asynchronous, active-low.
  - Asserting ic_n=0 immediately clears all presets, counters, start, mask and flags, and the prescaler.
  - Outputs during and after reset: status=8'h00, irq_n=1.
- Register writes: all register updates take effect one cycle after the wr_valid cycle.
- Preset write (wr_addr == PRESET_BASE_ADDR+i, i<NUM_TIMERS):
  - preset[i] <= wr_data[TIMER_WIDTH-1:0]; upper data bits are ignored if TIMER_WIDTH<8.
  - A running counter keeps its value; the new preset is used at the next load or reload.
- Control write (wr_addr == CTRL_ADDR):
  - If wr_data[7]=1: clear all flags. All other bits of that write are ignored (start and mask unchanged).
  - Else: mask[i] <= wr_data[6-i]; start[i] <= wr_data[i].
- Base prescaler:
  - Free-running counter 0..BASE_TICK_CYCLES-1.
  - base_tick is a 1-cycle pulse at wrap.
  - Runs regardless of start bits.
- Per-timer sub-divider:
  - Timer i counts base_ticks modulo 2^(TICK_SHIFT*i) and emits tick[i] on wrap.
  - tick[0] = base_tick.
  - Sub-dividers are free-running.
- Timer state, per timer:
  - STOPPED: counter holds. On start 0->1, load counter <= preset and go to RUNNING.
  - RUNNING:
    - On tick[i], if counter == all-ones: overflow. Counter <= preset; flag[i] <= 1 unless mask[i].
    - Otherwise on tick[i]: counter <= counter+1.
    - On start 1->0: go to STOPPED; counter holds.
  - Re-writing start=1 while already RUNNING does not reload.
- Overflow period: (2^TIMER_WIDTH - preset) ticks. Preset all-ones gives 1 tick.
- Mask:
  - A masked timer still counts and reloads but never sets its flag.
  - Setting mask does not clear an already-set flag.
- Flags are sticky until an IRQ-reset write (data bit7=1) or ic_n.
- Simultaneous overflow and IRQ-reset write in the same cycle: overflow wins, so the flag ends at 1.
- Simultaneous start 0->1 and tick in the same cycle: the load wins; the tick is discarded.
- Status is registered: status[6-i] = flag[i]; status[7] = OR of all flags.
  - A flag set at an overflow cycle appears on status/irq_n on the next cycle.
- Addresses that do not match any register are ignored.
- Unused status bits (6-i for i>=NUM_TIMERS, and bits 3..0) read 0.
- Elaboration error if NUM_TIMERS>3 or BASE_TICK_CYCLES<1.

Optional Feature:
- Macro: OPL_TIMER_EXT_TICK_EN.
- Defined:
  - The tick_ext port exists and the internal base prescaler is removed.
  - base_tick = tick_ext, sampled on clk with no synchroniser; the caller guarantees synchronous single-cycle pulses.
  - Sub-dividers and all other behaviour are unchanged.
- Undefined: no tick_ext port; the internal prescaler is used as specified.

Test Plan:
- Reset: drive ic_n low mid-count with flags set -> status=8'h00 and irq_n=1 immediately (asynchronously); counters restart from preset only after a new start.
- Timer 0, BASE_TICK_CYCLES=4, preset 8'hFE, ctrl write 8'h01:
  - Flag0 sets after 2 base ticks (about 8 clks).
  - status=8'hC0 and irq_n=0 one cycle later.
  - Subsequent overflows follow every 8 clks.
- Timer 1, BASE_TICK_CYCLES=4, TICK_SHIFT=2, preset 8'hFF, ctrl 8'h02 -> overflow every 16 clks; status=8'hA0.
- Mask: ctrl 8'h41 with preset 8'hFF -> timer 0 reloads every 4 clks, but status stays 8'h00 and irq_n stays 1.
- IRQ reset:
  - Write 8'h80 while flags are set -> status=8'h00 next cycle, and start/mask keep their prior values.
  - Repeat with the write landing on an overflow cycle -> the flag stays 1.
- Preset change while running: preset 8'hF0 to 8'hFC mid-count -> the current period finishes at the old count; the next period is 4 ticks.
